// File: rtl/priority_encoder_16x4_if.sv
// Request/code bus for priority_encoder_16x4: request lines in; one code at a time out,
// with a valid/ready handshake.
interface priority_encoder_16x4_if;
    logic [15:0] inputs;
    logic        enabled;
    logic        ready;
    logic [3:0]  outputs;
    logic        valid;
    logic [15:0] pending;
    logic        overrun;

    modport master (output inputs, enabled, ready,
                    input  outputs, valid, pending, overrun);
    modport slave  (input  inputs, enabled, ready,
                    output outputs, valid, pending, overrun);
endinterface

// File: rtl/priority_encoder_16x4.sv
// Sequential 16-to-4 priority encoder: latches request events and hands out one index per handshake.
// Define PRIORITY_ENCODER_ROUND_ROBIN_EN for rotating priority; otherwise index 15 always wins.
module priority_encoder_16x4 (
    input  logic                          clk,
    input  logic                          reset_n,
    priority_encoder_16x4_if.slave        bus
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t      state_q, state_d;
    logic [15:0] pend_q;
    logic [3:0]  code_q;
    logic        ovr_q;
    logic        accept;
    logic        load;
    logic [15:0] clr;
    logic [3:0]  sel;

    assign accept = (state_q == PRESENT) && bus.ready;
    assign clr    = accept ? (16'h0001 << code_q) : 16'h0000;
    assign load   = (state_q == IDLE) && bus.enabled && (pend_q != 16'h0000);

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
    logic [3:0] ptr_q;

    // Walk from the farthest candidate to the nearest so the nearest (ptr-1) wins.
    always_comb begin
        logic [3:0] idx;
        sel = 4'd0;
        idx = 4'd0;
        for (int k = 16; k >= 1; k--) begin
            idx = ptr_q - 4'(k);
            if (pend_q[idx]) sel = idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    ptr_q <= 4'd0;
        else if (accept) ptr_q <= code_q;
    end
`else
    always_comb begin
        sel = 4'd0;
        for (int i = 0; i < 16; i++)
            if (pend_q[i]) sel = 4'(i);
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load)      state_d = PRESENT;
            PRESENT: if (bus.ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Set beats clear on the same bit, so a re-pulse on the accepting edge survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 16'h0000;
            code_q <= 4'd0;
            ovr_q  <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~clr) | bus.inputs;
            ovr_q  <= |(bus.inputs & pend_q & ~clr);
            if (load) code_q <= sel;
        end
    end

    assign bus.outputs = code_q;
    assign bus.valid   = (state_q == PRESENT);
    assign bus.pending = pend_q;
    assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_priority_encoder_16x4.sv
// Directed bench for priority_encoder_16x4; works for both the fixed and round-robin builds.
module tb_priority_encoder_16x4;
    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    priority_encoder_16x4_if bus ();

    priority_encoder_16x4 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        bus.inputs  = 16'h0000;
        bus.enabled = 1'b0;
        bus.ready   = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rr_exp [4];
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        bus.inputs  = 16'h0000;
        bus.enabled = 1'b0;
        bus.ready   = 1'b0;
        #12;
        check("rst_outputs", 32'(bus.outputs), 32'd0);
        check("rst_valid",   32'(bus.valid),   32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        reset_n = 1'b1;
        step();

        // single request: latency and clear
        bus.enabled = 1'b1;
        bus.inputs  = 16'h0008;
        step();
        bus.inputs = 16'h0000;
        check("t1_pending", 32'(bus.pending), 32'h0008);
        check("t1_valid0",  32'(bus.valid),   32'd0);
        step();
        check("t1_valid",   32'(bus.valid),   32'd1);
        check("t1_code",    32'(bus.outputs), 32'd3);
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        check("t1_acc_valid",   32'(bus.valid),   32'd0);
        check("t1_acc_pending", 32'(bus.pending), 32'h0000);

        // three requests drained in priority order, ready held high
        do_reset();
        bus.enabled = 1'b1;
        bus.ready   = 1'b1;
        bus.inputs  = 16'h8101;
        step();
        bus.inputs = 16'h0000;
        check("t2_pending", 32'(bus.pending), 32'h8101);
        check("t2_idle0",   32'(bus.valid),   32'd0);
        step();
        check("t2_v15", 32'(bus.valid),   32'd1);
        check("t2_c15", 32'(bus.outputs), 32'd15);
        step();
        check("t2_gap1",  32'(bus.valid),   32'd0);
        check("t2_pend1", 32'(bus.pending), 32'h0101);
        step();
        check("t2_v8", 32'(bus.valid),   32'd1);
        check("t2_c8", 32'(bus.outputs), 32'd8);
        step();
        check("t2_gap2", 32'(bus.valid), 32'd0);
        step();
        check("t2_v0", 32'(bus.valid),   32'd1);
        check("t2_c0", 32'(bus.outputs), 32'd0);
        step();
        check("t2_gap3",  32'(bus.valid),   32'd0);
        check("t2_pend3", 32'(bus.pending), 32'h0000);

        // held 8001: rotating build alternates, fixed build keeps granting 15
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
        rr_exp = '{4'd15, 4'd0, 4'd15, 4'd0};
`else
        rr_exp = '{4'd15, 4'd15, 4'd15, 4'd15};
`endif
        do_reset();
        bus.enabled = 1'b1;
        bus.ready   = 1'b1;
        bus.inputs  = 16'h8001;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_valid", 32'(bus.valid),   32'd1);
            check("t3_code",  32'(bus.outputs), 32'(rr_exp[i]));
            step();
            check("t3_gap", 32'(bus.valid), 32'd0);
        end

        // overrun on a re-pulse of a pending, unaccepted bit
        do_reset();
        bus.inputs = 16'h0020;
        step();
        bus.inputs = 16'h0000;
        check("t4_pend",  32'(bus.pending), 32'h0020);
        check("t4_ovr0",  32'(bus.overrun), 32'd0);
        bus.inputs = 16'h0020;
        step();
        bus.inputs = 16'h0000;
        check("t4_ovr1",  32'(bus.overrun), 32'd1);
        check("t4_pend1", 32'(bus.pending), 32'h0020);
        step();
        check("t4_ovr_pulse", 32'(bus.overrun), 32'd0);
        bus.enabled = 1'b1;
        step();
        check("t4_valid", 32'(bus.valid),   32'd1);
        check("t4_code",  32'(bus.outputs), 32'd5);
        // re-pulse on the accepting edge: set wins, no overrun
        bus.ready  = 1'b1;
        bus.inputs = 16'h0020;
        step();
        bus.ready  = 1'b0;
        bus.inputs = 16'h0000;
        check("t4_acc_pend",  32'(bus.pending), 32'h0020);
        check("t4_acc_ovr",   32'(bus.overrun), 32'd0);
        check("t4_acc_valid", 32'(bus.valid),   32'd0);
        step();
        check("t4_revalid", 32'(bus.valid),   32'd1);
        check("t4_recode",  32'(bus.outputs), 32'd5);

        // dropping enabled mid-presentation does not retract valid
        do_reset();
        bus.enabled = 1'b1;
        bus.inputs  = 16'h0080;
        step();
        bus.inputs = 16'h0000;
        step();
        check("t5_valid", 32'(bus.valid),   32'd1);
        check("t5_code",  32'(bus.outputs), 32'd7);
        bus.enabled = 1'b0;
        bus.inputs  = 16'h0004;
        step();
        bus.inputs = 16'h0000;
        step();
        step();
        check("t5_hold_valid", 32'(bus.valid),   32'd1);
        check("t5_hold_code",  32'(bus.outputs), 32'd7);
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        check("t5_acc_valid", 32'(bus.valid),   32'd0);
        check("t5_acc_pend",  32'(bus.pending), 32'h0004);
        step();
        step();
        check("t5_dis_valid", 32'(bus.valid),   32'd0);
        check("t5_dis_pend",  32'(bus.pending), 32'h0004);

        // asynchronous reset mid-handshake
        bus.enabled = 1'b1;
        step();
        check("t6_valid", 32'(bus.valid),   32'd1);
        check("t6_code",  32'(bus.outputs), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.valid),   32'd0);
        check("t6_rst_code",  32'(bus.outputs), 32'd0);
        check("t6_rst_pend",  32'(bus.pending), 32'h0000);
        step();
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
